// File: rtl/fx_bus_master.sv
// fx register bus initiator: turns a host command byte stream into fx_wr/fx_rd strobes and read responses.
// Optional idle-byte timeout is compiled in with `define FX_TIMEOUT_EN.
module fx_bus_master #(
   parameter int RD_LAT  = 1,
   parameter int TIMEOUT = 1000
) (
   input  logic        clk_sys,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [21:0] fx_waddr,
   output logic        fx_wr,
   output logic [7:0]  fx_data,
   output logic [21:0] fx_raddr,
   output logic        fx_rd,
   input  logic [7:0]  fx_q,
   output logic        busy,
   output logic        cmd_err
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR2,
      S_ADDR1,
      S_ADDR0,
      S_CNT,
      S_WDATA,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_RD_SEND
   } state_t;

   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_READ  = 8'h02;
   localparam int         LAT_W    = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

   state_t           state, state_next;
   logic [5:0]       dev_id;
   logic [15:0]      reg_addr;
   logic [8:0]       remaining;
   logic             op_read;
   logic [LAT_W-1:0] lat_cnt;

   logic accept, handshake;
   logic bad_op, do_write, do_issue, capture, timeout_hit;

   function automatic logic takes_bytes(input state_t s);
      return (s == S_IDLE) || (s == S_ADDR2) || (s == S_ADDR1) ||
             (s == S_ADDR0) || (s == S_CNT) || (s == S_WDATA);
   endfunction

   assign accept    = rx_valid & rx_ready;
   assign handshake = tx_valid & tx_ready;
   assign busy      = (state != S_IDLE);

`ifdef FX_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] idle_cnt;
   logic            in_packet;

   assign in_packet   = takes_bytes(state) && (state != S_IDLE);
   // Fires on the TIMEOUT-th consecutive cycle without an accepted byte.
   assign timeout_hit = in_packet && !accept && (idle_cnt == TO_W'(TIMEOUT - 1));

   always_ff @(posedge clk_sys) begin
      if (rst || !in_packet || accept || timeout_hit)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk_sys) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      bad_op     = 1'b0;
      do_write   = 1'b0;
      do_issue   = 1'b0;
      capture    = 1'b0;
      case (state)
         S_IDLE:
            if (accept) begin
               if (rx_data == OP_WRITE || rx_data == OP_READ)
                  state_next = S_ADDR2;
               else
                  bad_op = 1'b1;
            end
         S_ADDR2:    if (accept) state_next = S_ADDR1;
         S_ADDR1:    if (accept) state_next = S_ADDR0;
         S_ADDR0:    if (accept) state_next = S_CNT;
         S_CNT:      if (accept) state_next = op_read ? S_RD_ISSUE : S_WDATA;
         S_WDATA:
            if (accept) begin
               do_write = 1'b1;
               if (remaining == 9'd1)
                  state_next = S_IDLE;
            end
         S_RD_ISSUE: begin
            do_issue   = 1'b1;
            state_next = S_RD_WAIT;
         end
         S_RD_WAIT:
            if (lat_cnt == LAT_W'(RD_LAT)) begin
               capture    = 1'b1;
               state_next = S_RD_SEND;
            end
         S_RD_SEND:
            if (handshake)
               state_next = (remaining == 9'd0) ? S_IDLE : S_RD_ISSUE;
         default:    state_next = S_IDLE;
      endcase
      if (timeout_hit)
         state_next = S_IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         rx_ready  <= 1'b0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
         fx_waddr  <= '0;
         fx_wr     <= 1'b0;
         fx_data   <= '0;
         fx_raddr  <= '0;
         fx_rd     <= 1'b0;
         cmd_err   <= 1'b0;
         dev_id    <= '0;
         reg_addr  <= '0;
         remaining <= '0;
         op_read   <= 1'b0;
         lat_cnt   <= '0;
      end else begin
         fx_wr    <= do_write;
         fx_rd    <= do_issue;
         cmd_err  <= bad_op | timeout_hit;
         rx_ready <= takes_bytes(state_next);

         if (accept) begin
            case (state)
               S_IDLE:  op_read         <= (rx_data == OP_READ);
               S_ADDR2: dev_id          <= rx_data[5:0];
               S_ADDR1: reg_addr[15:8]  <= rx_data;
               S_ADDR0: reg_addr[7:0]   <= rx_data;
               // A count byte of zero encodes 256 transfers.
               S_CNT:   remaining       <= {rx_data == 8'h00, rx_data};
               default: ;
            endcase
         end

         if (do_write) begin
            fx_waddr  <= {dev_id, reg_addr};
            fx_data   <= rx_data;
            reg_addr  <= reg_addr + 16'd1;
            remaining <= remaining - 9'd1;
         end

         if (do_issue) begin
            fx_raddr  <= {dev_id, reg_addr};
            reg_addr  <= reg_addr + 16'd1;
            remaining <= remaining - 9'd1;
            lat_cnt   <= '0;
         end else if (state == S_RD_WAIT) begin
            lat_cnt <= lat_cnt + 1'b1;
         end

         if (capture) begin
            tx_data  <= fx_q;
            tx_valid <= 1'b1;
         end else if (handshake) begin
            tx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fx_bus_master.sv
// Self-checking bench for fx_bus_master: directed packets, scoreboard queues and a registered slave model.
module tb_fx_bus_master;

   logic        clk_sys = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [21:0] fx_waddr;
   logic        fx_wr;
   logic [7:0]  fx_data;
   logic [21:0] fx_raddr;
   logic        fx_rd;
   logic [7:0]  fx_q;
   logic        busy;
   logic        cmd_err;

   int checks   = 0;
   int failures = 0;
   int wr_cnt   = 0;
   int rd_cnt   = 0;
   int cyc      = 0;
   int last_rd_cyc = 0;
   logic tx_valid_prev = 1'b0;

   logic [29:0] wr_q[$];
   logic [21:0] rd_q[$];
   logic [7:0]  tx_q[$];
   logic [7:0]  pkt[$];

   fx_bus_master #(.RD_LAT(1), .TIMEOUT(1000)) dut (
      .clk_sys  (clk_sys),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .fx_waddr (fx_waddr),
      .fx_wr    (fx_wr),
      .fx_data  (fx_data),
      .fx_raddr (fx_raddr),
      .fx_rd    (fx_rd),
      .fx_q     (fx_q),
      .busy     (busy),
      .cmd_err  (cmd_err)
   );

   always #5 clk_sys = ~clk_sys;

   // Slave on dev_id 5: register value equals low address byte, q registered one cycle after fx_rd.
   always @(posedge clk_sys)
      fx_q <= (fx_rd && fx_raddr[21:16] == 6'h05) ? fx_raddr[7:0] : 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk_sys) begin
      logic [29:0] we;
      logic [21:0] re;
      logic [7:0]  te;
      cyc++;
      if (fx_wr || fx_rd)
         check("strobe_exclusive", 32'(fx_wr & fx_rd), 32'd0);
      if (fx_wr) begin
         wr_cnt++;
         if (wr_q.size() == 0)
            check("wr_unexpected", 32'(wr_q.size()), 32'd1);
         else begin
            we = wr_q.pop_front();
            check("wr_addr", 32'(fx_waddr), 32'(we[29:8]));
            check("wr_data", 32'(fx_data), 32'(we[7:0]));
         end
      end
      if (fx_rd) begin
         rd_cnt++;
         last_rd_cyc = cyc;
         if (rd_q.size() == 0)
            check("rd_unexpected", 32'(rd_q.size()), 32'd1);
         else begin
            re = rd_q.pop_front();
            check("rd_addr", 32'(fx_raddr), 32'(re));
         end
      end
      if (tx_valid && !tx_valid_prev)
         check("rd_latency", 32'(cyc - last_rd_cyc), 32'd2);
      tx_valid_prev = tx_valid;
      if (tx_valid && tx_ready) begin
         if (tx_q.size() == 0)
            check("tx_unexpected", 32'(tx_q.size()), 32'd1);
         else begin
            te = tx_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(te));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int   n;
      logic ok;
      rx_data  = b;
      rx_valid = 1'b1;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 50) begin
         @(negedge clk_sys);
         ok = rx_ready;
         @(posedge clk_sys);
         #1;
         n++;
      end
      rx_valid = 1'b0;
      check("rx_accept", 32'(ok), 32'd1);
   endtask

   task automatic send_pkt();
      foreach (pkt[i]) send_byte(pkt[i]);
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n;
      n = 0;
      while ((busy || wr_q.size() != 0 || rd_q.size() != 0 || tx_q.size() != 0) && n < limit) begin
         @(negedge clk_sys);
         n++;
      end
      check(tag, 32'(n < limit), 32'd1);
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
      check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
      check({tag, "_tx_data"},  32'(tx_data),  32'd0);
      check({tag, "_fx_wr"},    32'(fx_wr),    32'd0);
      check({tag, "_fx_rd"},    32'(fx_rd),    32'd0);
      check({tag, "_fx_waddr"}, 32'(fx_waddr), 32'd0);
      check({tag, "_fx_raddr"}, 32'(fx_raddr), 32'd0);
      check({tag, "_fx_data"},  32'(fx_data),  32'd0);
      check({tag, "_busy"},     32'(busy),     32'd0);
      check({tag, "_cmd_err"},  32'(cmd_err),  32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int saved_rd;
      int saved_wr;

      rst      = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      @(negedge clk_sys);
      check_reset_values("reset");
      @(posedge clk_sys);
      #1;
      rst = 1'b0;
      @(posedge clk_sys);
      #1;
      @(negedge clk_sys);
      check("rx_ready_after_reset", 32'(rx_ready), 32'd1);
      @(posedge clk_sys);
      #1;

      // Single write; strobe must land the cycle after the data byte.
      wr_q.push_back({22'h050020, 8'h5A});
      pkt = {8'h01, 8'h05, 8'h00, 8'h20, 8'h01, 8'h5A};
      send_pkt();
      @(negedge clk_sys);
      check("wr_strobe_next_cycle", 32'(fx_wr), 32'd1);
      @(posedge clk_sys);
      #1;
      @(negedge clk_sys);
      check("busy_after_write", 32'(busy), 32'd0);
      check("wr_q_drained", 32'(wr_q.size()), 32'd0);
      @(posedge clk_sys);
      #1;

      // Three-byte read burst with host always ready.
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rd_q.push_back(22'h050080 + 22'(i));
         tx_q.push_back(8'h80 + 8'(i));
      end
      pkt = {8'h02, 8'h05, 8'h00, 8'h80, 8'h03};
      send_pkt();
      wait_idle("read3_done", 200);

      // Host stalls for 10 cycles: response held, no new strobe, no byte intake.
      tx_ready = 1'b0;
      rd_q.push_back(22'h050090);
      rd_q.push_back(22'h050091);
      tx_q.push_back(8'h90);
      tx_q.push_back(8'h91);
      pkt = {8'h02, 8'h05, 8'h00, 8'h90, 8'h02};
      send_pkt();
      n = 0;
      while (!tx_valid && n < 50) begin
         @(negedge clk_sys);
         n++;
      end
      check("stall_tx_valid_seen", 32'(tx_valid), 32'd1);
      saved_rd = rd_cnt;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_sys);
         check("stall_tx_data", 32'(tx_data), 32'h90);
         check("stall_tx_valid", 32'(tx_valid), 32'd1);
         check("stall_rx_ready", 32'(rx_ready), 32'd0);
      end
      check("stall_no_extra_rd", 32'(rd_cnt), 32'(saved_rd));
      @(posedge clk_sys);
      #1;
      tx_ready = 1'b1;
      wait_idle("stall_read_done", 200);

      // Write burst across the 16-bit address wrap; A2[7:6] must be ignored.
      wr_q.push_back({22'h05FFFF, 8'h11});
      wr_q.push_back({22'h050000, 8'h22});
      pkt = {8'h01, 8'hC5, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h22};
      send_pkt();
      wait_idle("wrap_write_done", 50);

      // Count byte 0 means 256 reads.
      for (int i = 0; i < 256; i++) begin
         rd_q.push_back(22'h051200 + 22'(i));
         tx_q.push_back(8'(i));
      end
      saved_rd = rd_cnt;
      pkt = {8'h02, 8'h05, 8'h12, 8'h00, 8'h00};
      send_pkt();
      wait_idle("read256_done", 3000);
      check("read256_count", 32'(rd_cnt - saved_rd), 32'd256);

      // Bad opcode: one-cycle cmd_err, stays idle, no strobes, next packet works.
      saved_wr = wr_cnt;
      saved_rd = rd_cnt;
      send_byte(8'h33);
      @(negedge clk_sys);
      check("bad_op_cmd_err", 32'(cmd_err), 32'd1);
      check("bad_op_idle", 32'(busy), 32'd0);
      @(posedge clk_sys);
      #1;
      @(negedge clk_sys);
      check("bad_op_pulse_end", 32'(cmd_err), 32'd0);
      check("bad_op_no_wr", 32'(wr_cnt), 32'(saved_wr));
      check("bad_op_no_rd", 32'(rd_cnt), 32'(saved_rd));
      @(posedge clk_sys);
      #1;
      wr_q.push_back({22'h050040, 8'h77});
      pkt = {8'h01, 8'h05, 8'h00, 8'h40, 8'h01, 8'h77};
      send_pkt();
      wait_idle("after_bad_op_done", 50);

      // Host pauses mid-packet; without the timeout option the packet simply resumes.
      wr_q.push_back({22'h050050, 8'h66});
      pkt = {8'h01, 8'h05, 8'h00, 8'h50, 8'h01};
      send_pkt();
      repeat (20) @(posedge clk_sys);
      #1;
      @(negedge clk_sys);
      check("pause_busy", 32'(busy), 32'd1);
      check("pause_no_err", 32'(cmd_err), 32'd0);
      @(posedge clk_sys);
      #1;
      send_byte(8'h66);
      wait_idle("pause_write_done", 50);

      // Reset in the middle of a write burst.
      wr_q.push_back({22'h050060, 8'hA1});
      pkt = {8'h01, 8'h05, 8'h00, 8'h60, 8'h03, 8'hA1};
      send_pkt();
      rst      = 1'b1;
      rx_data  = 8'hA2;
      rx_valid = 1'b1;
      @(posedge clk_sys);
      #1;
      rx_valid = 1'b0;
      @(negedge clk_sys);
      check_reset_values("mid_rst");
      @(posedge clk_sys);
      #1;
      rst = 1'b0;
      @(posedge clk_sys);
      #1;
      @(negedge clk_sys);
      check("rx_ready_after_mid_rst", 32'(rx_ready), 32'd1);
      check("mid_rst_wr_q", 32'(wr_q.size()), 32'd0);
      @(posedge clk_sys);
      #1;
      wr_q.push_back({22'h050070, 8'hB2});
      pkt = {8'h01, 8'h05, 8'h00, 8'h70, 8'h01, 8'hB2};
      send_pkt();
      wait_idle("after_rst_done", 50);

      repeat (5) @(posedge clk_sys);
      #1;
      check("final_wr_q_empty", 32'(wr_q.size()), 32'd0);
      check("final_rd_q_empty", 32'(rd_q.size()), 32'd0);
      check("final_tx_q_empty", 32'(tx_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
